// File: rtl/oflow_event_scheduler.sv
// Round-robin scheduler of per-core task-count inc/dec events onto the single inc and dec
// channels of the overflow counter block, holding back events that hit a recently issued task.
module oflow_event_scheduler #(
  parameter int NUM_CORES       = 4,
  parameter int KEY_WIDTH       = 4,
  parameter int HAZARD_WINDOW   = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           arb_enable,
  input  logic [NUM_CORES-1:0]           inc_valid,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] inc_task_id,
  input  logic [NUM_CORES-1:0]           inc_logical_core_id,
  output logic [NUM_CORES-1:0]           inc_ready,
  input  logic [NUM_CORES-1:0]           dec_valid,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] dec_task_id,
  output logic [NUM_CORES-1:0]           dec_ready,
  output logic                           count_inc,
  output logic [KEY_WIDTH-1:0]           count_inc_task_id,
  output logic                           count_inc_logical_core_id,
  output logic [KEY_WIDTH-1:0]           count_inc_physical_core_id,
  output logic                           count_dec,
  output logic [KEY_WIDTH-1:0]           count_dec_task_id,
  output logic [STALL_CNT_WIDTH-1:0]     hazard_stall_count
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int KW    = KEY_WIDTH;
  localparam int HW    = HAZARD_WINDOW;

  logic [PTR_W-1:0]   inc_ptr;
  logic [PTR_W-1:0]   dec_ptr;
  logic [HW-1:0]      hist_inc_vld;
  logic [HW*KW-1:0]   hist_inc_task;
  logic [HW-1:0]      hist_dec_vld;
  logic [HW*KW-1:0]   hist_dec_task;

  logic               arb_on;
  logic [NUM_CORES-1:0] inc_elig;
  logic [NUM_CORES-1:0] inc_blk;
  logic [NUM_CORES-1:0] inc_gnt;
  logic               inc_gnt_vld;
  logic [PTR_W-1:0]   inc_gnt_idx;
  logic [KW-1:0]      inc_gnt_task;
  logic [NUM_CORES-1:0] dec_elig;
  logic [NUM_CORES-1:0] dec_blk;
  logic [NUM_CORES-1:0] dec_gnt;
  logic               dec_gnt_vld;
  logic [PTR_W-1:0]   dec_gnt_idx;
  logic [KW-1:0]      dec_gnt_task;
  logic               stall_evt;

  function automatic logic in_history(
    input logic [KW-1:0]    t,
    input logic [HW-1:0]    iv,
    input logic [HW*KW-1:0] it,
    input logic [HW-1:0]    dv,
    input logic [HW*KW-1:0] dt
  );
    logic hit;
    hit = 1'b0;
    for (int h = 0; h < HW; h++) begin
      if (iv[h] && (it[h*KW +: KW] == t)) hit = 1'b1;
      if (dv[h] && (dt[h*KW +: KW] == t)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_next(input logic [PTR_W-1:0] idx);
    return (int'(idx) == NUM_CORES - 1) ? '0 : idx + 1'b1;
  endfunction

  // Grants are withheld while reset is asserted so ready stays low throughout reset.
  assign arb_on = arb_enable & reset_n;

  always_comb begin
    inc_elig    = '0;
    inc_blk     = '0;
    inc_gnt     = '0;
    inc_gnt_vld = 1'b0;
    inc_gnt_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_on && inc_valid[i]) begin
        if (in_history(inc_task_id[i*KW +: KW], hist_inc_vld, hist_inc_task,
                       hist_dec_vld, hist_dec_task))
          inc_blk[i] = 1'b1;
        else
          inc_elig[i] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CORES; k++) begin : inc_scan
      int idx;
      idx = (int'(inc_ptr) + k) % NUM_CORES;
      if (!inc_gnt_vld && inc_elig[idx]) begin
        inc_gnt_vld = 1'b1;
        inc_gnt_idx = PTR_W'(idx);
      end
    end
    inc_gnt[inc_gnt_idx] = inc_gnt_vld;
    inc_gnt_task         = inc_task_id[inc_gnt_idx*KW +: KW];
  end

  // A dec whose task matches this cycle's inc grant waits; the inc always wins the tie.
  always_comb begin
    dec_elig    = '0;
    dec_blk     = '0;
    dec_gnt     = '0;
    dec_gnt_vld = 1'b0;
    dec_gnt_idx = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (arb_on && dec_valid[j]) begin
        if (in_history(dec_task_id[j*KW +: KW], hist_inc_vld, hist_inc_task,
                       hist_dec_vld, hist_dec_task) ||
            (inc_gnt_vld && (dec_task_id[j*KW +: KW] == inc_gnt_task)))
          dec_blk[j] = 1'b1;
        else
          dec_elig[j] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CORES; k++) begin : dec_scan
      int idx;
      idx = (int'(dec_ptr) + k) % NUM_CORES;
      if (!dec_gnt_vld && dec_elig[idx]) begin
        dec_gnt_vld = 1'b1;
        dec_gnt_idx = PTR_W'(idx);
      end
    end
    dec_gnt[dec_gnt_idx] = dec_gnt_vld;
    dec_gnt_task         = dec_task_id[dec_gnt_idx*KW +: KW];
  end

  assign stall_evt = (|inc_blk) | (|dec_blk);
  assign inc_ready = inc_gnt;
  assign dec_ready = dec_gnt;

  // Issue stage: registered pulses to the counter block, pointer advance, hazard history shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_inc                  <= 1'b0;
      count_inc_task_id          <= '0;
      count_inc_logical_core_id  <= 1'b0;
      count_inc_physical_core_id <= '0;
      count_dec                  <= 1'b0;
      count_dec_task_id          <= '0;
      inc_ptr                    <= '0;
      dec_ptr                    <= '0;
      hist_inc_vld               <= '0;
      hist_inc_task              <= '0;
      hist_dec_vld               <= '0;
      hist_dec_task              <= '0;
      hazard_stall_count         <= '0;
    end else begin
      count_inc <= inc_gnt_vld;
      count_dec <= dec_gnt_vld;
      if (inc_gnt_vld) begin
        count_inc_task_id          <= inc_gnt_task;
        count_inc_logical_core_id  <= inc_logical_core_id[inc_gnt_idx];
        count_inc_physical_core_id <= KW'(inc_gnt_idx);
        inc_ptr                    <= wrap_next(inc_gnt_idx);
      end
      if (dec_gnt_vld) begin
        count_dec_task_id <= dec_gnt_task;
        dec_ptr           <= wrap_next(dec_gnt_idx);
      end
      for (int h = HW - 1; h > 0; h--) begin
        hist_inc_vld[h]             <= hist_inc_vld[h-1];
        hist_inc_task[h*KW +: KW]   <= hist_inc_task[(h-1)*KW +: KW];
        hist_dec_vld[h]             <= hist_dec_vld[h-1];
        hist_dec_task[h*KW +: KW]   <= hist_dec_task[(h-1)*KW +: KW];
      end
      hist_inc_vld[0]       <= inc_gnt_vld;
      hist_inc_task[0 +: KW] <= inc_gnt_task;
      hist_dec_vld[0]       <= dec_gnt_vld;
      hist_dec_task[0 +: KW] <= dec_gnt_task;
      if (stall_evt && (hazard_stall_count != '1))
        hazard_stall_count <= hazard_stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_oflow_event_scheduler.sv
// Scoreboard bench for oflow_event_scheduler: directed scenarios plus random traffic checked
// against a per-task "last issued cycle" reference model.
module tb_oflow_event_scheduler;
  localparam int N   = 4;
  localparam int KW  = 4;
  localparam int HW  = 1;
  localparam int SW  = 8;
  localparam int SAT = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arb_enable = 1'b0;
  logic [N-1:0]    inc_valid = '0;
  logic [N*KW-1:0] inc_task_id = '0;
  logic [N-1:0]    inc_logical_core_id = '0;
  logic [N-1:0]    inc_ready;
  logic [N-1:0]    dec_valid = '0;
  logic [N*KW-1:0] dec_task_id = '0;
  logic [N-1:0]    dec_ready;
  logic            count_inc;
  logic [KW-1:0]   count_inc_task_id;
  logic            count_inc_logical_core_id;
  logic [KW-1:0]   count_inc_physical_core_id;
  logic            count_dec;
  logic [KW-1:0]   count_dec_task_id;
  logic [SW-1:0]   hazard_stall_count;

  oflow_event_scheduler #(
    .NUM_CORES(N), .KEY_WIDTH(KW), .HAZARD_WINDOW(HW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arb_enable(arb_enable),
    .inc_valid(inc_valid), .inc_task_id(inc_task_id),
    .inc_logical_core_id(inc_logical_core_id), .inc_ready(inc_ready),
    .dec_valid(dec_valid), .dec_task_id(dec_task_id), .dec_ready(dec_ready),
    .count_inc(count_inc), .count_inc_task_id(count_inc_task_id),
    .count_inc_logical_core_id(count_inc_logical_core_id),
    .count_inc_physical_core_id(count_inc_physical_core_id),
    .count_dec(count_dec), .count_dec_task_id(count_dec_task_id),
    .hazard_stall_count(hazard_stall_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int stamp; int tsk; int lcid; int pcid; } ev_t;
  ev_t inc_q[$];
  ev_t dec_q[$];

  // Requester state: what each core presents at the next cycle.
  bit rq_iv[N];
  int rq_it[N];
  bit rq_il[N];
  bit rq_dv[N];
  int rq_dt[N];

  // Reference model: a task is blocked while fewer than HW+1 cycles have passed since it issued.
  int last_issue[1 << KW];
  int m_iptr, m_dptr, m_stall;

  function automatic bit blocked(input int t, input int c);
    return (c - last_issue[t]) <= HW;
  endfunction

  task automatic model_reset();
    m_iptr = 0;
    m_dptr = 0;
    m_stall = 0;
    for (int t = 0; t < (1 << KW); t++) last_issue[t] = -1000;
    inc_q.delete();
    dec_q.delete();
  endtask

  task automatic clear_rq();
    for (int i = 0; i < N; i++) begin
      rq_iv[i] = 1'b0; rq_dv[i] = 1'b0;
    end
  endtask

  task automatic set_inc(input int i, input int t, input bit l);
    rq_iv[i] = 1'b1; rq_it[i] = t; rq_il[i] = l;
  endtask

  task automatic set_dec(input int i, input int t);
    rq_dv[i] = 1'b1; rq_dt[i] = t;
  endtask

  task automatic step(input bit en, input bit rst_n_i);
    int c, ig, dg, idx;
    bit stall_now, same;
    logic [N-1:0] exp_ir, exp_dr;
    @(negedge clk);
    if (reset_n && rst_n_i)
      check("stall_count", 64'(hazard_stall_count), 64'(m_stall));
    reset_n = rst_n_i;
    arb_enable = en;
    for (int i = 0; i < N; i++) begin
      inc_valid[i] = rq_iv[i];
      inc_task_id[i*KW +: KW] = KW'(rq_it[i]);
      inc_logical_core_id[i] = rq_il[i];
      dec_valid[i] = rq_dv[i];
      dec_task_id[i*KW +: KW] = KW'(rq_dt[i]);
    end
    #1;
    if (!rst_n_i) begin
      model_reset();
      check("rst_count_inc", 64'(count_inc), 64'(0));
      check("rst_count_dec", 64'(count_dec), 64'(0));
      check("rst_ids", 64'({count_inc_task_id, count_inc_logical_core_id,
                            count_inc_physical_core_id, count_dec_task_id}), 64'(0));
      check("rst_stall", 64'(hazard_stall_count), 64'(0));
      check("rst_ready", 64'({inc_ready, dec_ready}), 64'(0));
      return;
    end
    c = cyc; ig = -1; dg = -1; stall_now = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_iptr + k) % N;
        if (ig < 0 && rq_iv[idx] && !blocked(rq_it[idx], c)) ig = idx;
      end
      for (int k = 0; k < N; k++) begin
        idx = (m_dptr + k) % N;
        same = (ig >= 0) && (rq_dt[idx] == rq_it[ig]);
        if (dg < 0 && rq_dv[idx] && !blocked(rq_dt[idx], c) && !same) dg = idx;
      end
      for (int i = 0; i < N; i++) begin
        same = (ig >= 0) && (rq_dt[i] == rq_it[ig]);
        if (rq_iv[i] && blocked(rq_it[i], c)) stall_now = 1'b1;
        if (rq_dv[i] && (blocked(rq_dt[i], c) || same)) stall_now = 1'b1;
      end
    end
    exp_ir = '0; exp_dr = '0;
    if (ig >= 0) exp_ir[ig] = 1'b1;
    if (dg >= 0) exp_dr[dg] = 1'b1;
    check("inc_ready", 64'(inc_ready), 64'(exp_ir));
    check("dec_ready", 64'(dec_ready), 64'(exp_dr));
    if (ig >= 0) begin
      inc_q.push_back(ev_t'{c + 1, rq_it[ig], int'(rq_il[ig]), ig});
      last_issue[rq_it[ig]] = c;
      m_iptr = (ig + 1) % N;
      rq_iv[ig] = 1'b0;
    end
    if (dg >= 0) begin
      dec_q.push_back(ev_t'{c + 1, rq_dt[dg], 0, dg});
      last_issue[rq_dt[dg]] = c;
      m_dptr = (dg + 1) % N;
      rq_dv[dg] = 1'b0;
    end
    if (stall_now && m_stall < SAT) m_stall++;
  endtask

  // Monitor: every presented pulse must match the oldest expected event, including its cycle.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (count_inc === 1'b1) begin
        if (inc_q.size() == 0) check("inc_unexpected_pulse", 64'(1), 64'(0));
        else begin
          e = inc_q.pop_front();
          check("inc_pulse_cycle", 64'(cyc), 64'(e.stamp));
          check("inc_task", 64'(count_inc_task_id), 64'(e.tsk));
          check("inc_lcid", 64'(count_inc_logical_core_id), 64'(e.lcid));
          check("inc_pcid", 64'(count_inc_physical_core_id), 64'(e.pcid));
        end
      end
      if (count_dec === 1'b1) begin
        if (dec_q.size() == 0) check("dec_unexpected_pulse", 64'(1), 64'(0));
        else begin
          e = dec_q.pop_front();
          check("dec_pulse_cycle", 64'(cyc), 64'(e.stamp));
          check("dec_task", 64'(count_dec_task_id), 64'(e.tsk));
        end
      end
    end
  end

  initial begin
    clear_rq();
    for (int i = 0; i < N; i++) begin
      rq_it[i] = 0; rq_il[i] = 1'b0; rq_dt[i] = 0;
    end
    model_reset();
    repeat (3) step(1'b0, 1'b0);

    // Round robin with every core constantly requesting a distinct task.
    for (int i = 0; i < N; i++) set_inc(i, i + 1, 1'(i & 1));
    repeat (12) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < N; i++) if (!rq_iv[i]) set_inc(i, i + 1, 1'(i & 1));
    end

    // Reset in the middle of traffic; the first grant afterwards belongs to core 0.
    for (int i = 0; i < N; i++) begin
      set_inc(i, i + 1, 1'(i & 1));
      set_dec(i, i + 8);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("first_grant_after_reset", 64'(inc_ready), 64'(4'b0001));
    clear_rq();
    repeat (3) step(1'b1, 1'b1);

    // Two cores incrementing the same task in the same cycle.
    step(1'b0, 1'b0);
    set_inc(0, 5, 1'b0);
    set_inc(1, 5, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    check("same_task_inc_stall", 64'(hazard_stall_count), 64'(1));

    // Inc and dec of one task in the same cycle: the inc goes first.
    step(1'b0, 1'b0);
    set_inc(2, 7, 1'b1);
    set_dec(3, 7);
    repeat (4) step(1'b1, 1'b1);
    check("inc_dec_collision_stall", 64'(hazard_stall_count), 64'(2));

    // Independent inc and dec issue in parallel.
    step(1'b0, 1'b0);
    set_inc(1, 3, 1'b0);
    set_dec(0, 9);
    step(1'b1, 1'b1);
    check("parallel_inc_ready", 64'(inc_ready), 64'(4'b0010));
    check("parallel_dec_ready", 64'(dec_ready), 64'(4'b0001));
    step(1'b1, 1'b1);
    check("parallel_pulses", 64'({count_inc, count_dec}), 64'(2'b11));
    check("parallel_pcid", 64'(count_inc_physical_core_id), 64'(1));

    // Arbitration disabled with requests pending.
    step(1'b0, 1'b0);
    for (int i = 0; i < N; i++) set_inc(i, 10 + i, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check("disabled_no_pulse", 64'({count_inc, count_dec}), 64'(0));

    // Permanent hazard on every cycle drives the stall counter to saturation.
    step(1'b0, 1'b0);
    clear_rq();
    set_inc(0, 6, 1'b0);
    set_dec(1, 6);
    repeat (SAT + 40) begin
      step(1'b1, 1'b1);
      if (!rq_iv[0]) set_inc(0, 6, 1'b0);
    end
    check("stall_saturated", 64'(hazard_stall_count), 64'(SAT));

    // Random traffic over a small task space to provoke frequent collisions.
    step(1'b0, 1'b0);
    clear_rq();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_iv[i] && $urandom_range(0, 1) == 1)
          set_inc(i, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        if (!rq_dv[i] && $urandom_range(0, 2) == 0)
          set_dec(i, int'($urandom_range(0, 7)));
      end
      if (n == 400) step(1'b1, 1'b0);
      else step($urandom_range(0, 9) != 0, 1'b1);
    end

    clear_rq();
    repeat (4) step(1'b1, 1'b1);
    check("inc_queue_drained", 64'(inc_q.size()), 64'(0));
    check("dec_queue_drained", 64'(dec_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
